// File: rtl/sprite_motion_ctrl.sv
// Player sprite motion controller: latches a direction from the push-buttons, steps a shadow
// position on a fixed tick, and commits it to the renderer outputs only on a frame start.
`timescale 1ns/1ps
module sprite_motion_ctrl #(
    parameter int unsigned SCREEN_W = 96,
    parameter int unsigned SCREEN_H = 64,
    parameter int unsigned SPR_W    = 10,
    parameter int unsigned SPR_H    = 10,
    parameter int unsigned START_X  = 0,
    parameter int unsigned START_Y  = 54,
    parameter int unsigned OBS_X    = 66,
    parameter int unsigned OBS_Y    = 0,
    parameter int unsigned OBS_W    = 30,
    parameter int unsigned OBS_H    = 30,
    parameter int unsigned TICK_DIV = 1666666
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       frame_begin,
    output logic [6:0] pos_x,
    output logic [5:0] pos_y,
    output logic [2:0] dir,
    output logic       step_tick,
    output logic       blocked
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    localparam logic [7:0] ObsX0 = 8'(OBS_X);
    localparam logic [7:0] ObsX1 = 8'(OBS_X + OBS_W);
    localparam logic [7:0] ObsY0 = 8'(OBS_Y);
    localparam logic [7:0] ObsY1 = 8'(OBS_Y + OBS_H);
    localparam logic [7:0] SprW  = 8'(SPR_W);
    localparam logic [7:0] SprH  = 8'(SPR_H);
    localparam logic [7:0] ScrW  = 8'(SCREEN_W);
    localparam logic [7:0] ScrH  = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        DirNone  = 3'd0,
        DirLeft  = 3'd1,
        DirRight = 3'd2,
        DirUp    = 3'd3,
        DirDown  = 3'd4
    } dir_e;

    dir_e            dir_q, dir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      shadow_x_q, shadow_x_d, pos_x_q, pos_x_d;
    logic [5:0]      shadow_y_q, shadow_y_d, pos_y_q, pos_y_d;
    logic [3:0]      btn_q, btn_now, btn_rise;
    logic            fb_q, blocked_q, blocked_d;

    // Button vector order {L, R, U, D} so bit 3 carries the highest priority.
    assign btn_now  = {btnL, btnR, btnU, btnD};
    assign btn_rise = btn_now & ~btn_q;

    function automatic dir_e pick_dir(input logic [3:0] b);
        if (b[3])      return DirLeft;
        else if (b[2]) return DirRight;
        else if (b[1]) return DirUp;
        else if (b[0]) return DirDown;
        else           return DirNone;
    endfunction

    always_comb begin
        dir_d = dir_q;
        if (!enable)         dir_d = DirNone;
        else if (|btn_rise)  dir_d = pick_dir(btn_rise);
        else if (|btn_now)   dir_d = pick_dir(btn_now);
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || cnt_q == CntMax) cnt_d = '0;
    end

    assign step_tick = (cnt_q == CntMax);

    logic [6:0] nx;
    logic [5:0] ny;
    logic [7:0] sx, sy, cx, cy;
    logic       edge_hit, overlap, moving, accept;

    assign sx = {1'b0, shadow_x_q};
    assign sy = {2'b00, shadow_y_q};

    always_comb begin
        nx       = shadow_x_q;
        ny       = shadow_y_q;
        edge_hit = 1'b0;
        case (dir_q)
            DirLeft:  begin edge_hit = (sx == 8'd0);       nx = shadow_x_q - 7'd1; end
            DirRight: begin edge_hit = (sx + SprW == ScrW); nx = shadow_x_q + 7'd1; end
            DirUp:    begin edge_hit = (sy == 8'd0);       ny = shadow_y_q - 6'd1; end
            DirDown:  begin edge_hit = (sy + SprH == ScrH); ny = shadow_y_q + 6'd1; end
            default:  ;
        endcase
    end

    // Wrapped candidates only occur when edge_hit already refuses the step.
    assign cx      = {1'b0, nx};
    assign cy      = {2'b00, ny};
    assign overlap = (cx < ObsX1) && (cx + SprW > ObsX0) && (cy < ObsY1) && (cy + SprH > ObsY0);
    assign moving  = (dir_q != DirNone);
    assign accept  = step_tick && moving && !edge_hit && !overlap;

    always_comb begin
        blocked_d  = step_tick && moving && (edge_hit || overlap);
        shadow_x_d = accept ? nx : shadow_x_q;
        shadow_y_d = accept ? ny : shadow_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        // Commit reads the pre-step shadow; a same-cycle step shows on the next frame.
        if (frame_begin && !fb_q) begin
            pos_x_d = shadow_x_q;
            pos_y_d = shadow_y_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q      <= DirNone;
            cnt_q      <= '0;
            shadow_x_q <= 7'(START_X);
            shadow_y_q <= 6'(START_Y);
            pos_x_q    <= 7'(START_X);
            pos_y_q    <= 6'(START_Y);
            btn_q      <= '0;
            fb_q       <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            btn_q      <= btn_now;
            fb_q       <= frame_begin;
            blocked_q  <= blocked_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: table of input segments with expected outputs queued as a
// scoreboard, plus hand-written sequences for async reset and the obstacle boundary.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic frame_begin = 1'b0;

    logic [6:0] pos_x, b_pos_x, c_pos_x;
    logic [5:0] pos_y, b_pos_y, c_pos_y;
    logic [2:0] dir, b_dir, c_dir;
    logic       step_tick, b_step_tick, c_step_tick;
    logic       blocked, b_blocked, c_blocked;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .frame_begin(frame_begin),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .step_tick(step_tick), .blocked(blocked)
    );

    // Sprite touching the obstacle's left edge: a right step overlaps it.
    sprite_motion_ctrl #(.TICK_DIV(4), .START_X(56), .START_Y(10)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .frame_begin(frame_begin),
        .pos_x(b_pos_x), .pos_y(b_pos_y), .dir(b_dir), .step_tick(b_step_tick),
        .blocked(b_blocked)
    );

    // Sprite just below the obstacle: touching its bottom edge is not overlap.
    sprite_motion_ctrl #(.TICK_DIV(4), .START_X(56), .START_Y(30)) dut_c (
        .clk(clk), .reset(reset), .enable(enable),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .frame_begin(frame_begin),
        .pos_x(c_pos_x), .pos_y(c_pos_y), .dir(c_dir), .step_tick(c_step_tick),
        .blocked(c_blocked)
    );

    typedef struct {
        bit       en;
        bit [3:0] btn;      // {L, R, U, D}
        bit       fb;
        int       cycles;
        int       exp_dir;
        int       exp_x;
        int       exp_y;
        int       exp_ticks;
        int       exp_blk;
    } vec_t;

    vec_t tbl[16];
    vec_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int ticks, blks, blks_b, blks_c;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, inputs changed only after that.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        ticks  += int'(step_tick);
        blks   += int'(blocked);
        blks_b += int'(b_blocked);
        blks_c += int'(c_blocked);
    endtask

    task automatic drive(input bit en, input bit [3:0] btn, input bit fb);
        enable = en;
        {btnL, btnR, btnU, btnD} = btn;
        frame_begin = fb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   n;

        tbl[0]  = '{1, 4'b1000, 0,  8, 1, 0, 54,  2, 2};  // left at x=0: refused twice
        tbl[1]  = '{1, 4'b0100, 0, 12, 2, 0, 54,  3, 0};  // three right steps, not committed
        tbl[2]  = '{1, 4'b0100, 1,  1, 2, 3, 54,  0, 0};  // commit x=3
        tbl[3]  = '{1, 4'b0000, 0,  2, 2, 3, 54,  1, 0};  // sticky direction after release
        tbl[4]  = '{1, 4'b1010, 0,  1, 1, 3, 54,  0, 0};  // L and U rise together -> LEFT
        tbl[5]  = '{1, 4'b0000, 0,  2, 1, 3, 54,  0, 0};
        tbl[6]  = '{0, 4'b0000, 0,  6, 0, 3, 54,  0, 0};  // disabled: NO_MOVE, counter frozen
        tbl[7]  = '{1, 4'b0000, 1,  1, 0, 4, 54,  0, 0};  // commit x=4
        tbl[8]  = '{1, 4'b0100, 1, 10, 2, 4, 54,  3, 0};  // frame_begin held: no re-commit
        tbl[9]  = '{1, 4'b0000, 0,  1, 2, 4, 54,  0, 0};
        tbl[10] = '{1, 4'b0000, 0,  3, 2, 4, 54,  1, 0};
        tbl[11] = '{1, 4'b0000, 1,  1, 2, 7, 54,  0, 0};  // commit coincides with step: old x
        tbl[12] = '{1, 4'b0000, 0,  1, 2, 7, 54,  0, 0};
        tbl[13] = '{1, 4'b0000, 1,  1, 2, 8, 54,  0, 0};  // next frame shows new x
        tbl[14] = '{1, 4'b0010, 0, 56, 3, 8, 54, 14, 0};  // fourteen up steps
        tbl[15] = '{1, 4'b0000, 1,  1, 3, 8, 40,  1, 0};  // commit (8,40)

        ticks = 0; blks = 0; blks_b = 0; blks_c = 0;
        drive(0, 4'b0000, 0);
        reset = 1'b0;
        cycle();
        cycle();
        check("reset pos_x", int'(pos_x), 0);
        check("reset pos_y", int'(pos_y), 54);
        check("reset dir", int'(dir), 0);
        check("reset step_tick", int'(step_tick), 0);
        check("reset blocked", int'(blocked), 0);

        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].btn, tbl[i].fb);
            sb_q.push_back(tbl[i]);
            ticks = 0;
            blks  = 0;
            repeat (tbl[i].cycles) cycle();
            e = sb_q.pop_front();
            check($sformatf("v%0d dir", i), int'(dir), e.exp_dir);
            check($sformatf("v%0d pos_x", i), int'(pos_x), e.exp_x);
            check($sformatf("v%0d pos_y", i), int'(pos_y), e.exp_y);
            check($sformatf("v%0d ticks", i), ticks, e.exp_ticks);
            check($sformatf("v%0d blocked", i), blks, e.exp_blk);
        end

        // Asynchronous reset in the middle of a clock phase.
        drive(1, 4'b0010, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async pos_x", int'(pos_x), 0);
        check("async pos_y", int'(pos_y), 54);
        check("async dir", int'(dir), 0);
        check("async step_tick", int'(step_tick), 0);
        check("async blocked", int'(blocked), 0);
        check("async b pos_x", int'(b_pos_x), 56);
        check("async c pos_y", int'(c_pos_y), 30);
        cycle();
        cycle();
        drive(1, 4'b0000, 0);
        reset = 1'b1;
        n = 0;
        ticks = 0;
        while (ticks == 0 && n < 20) begin
            cycle();
            n++;
        end
        check("first tick after reset", n, 3);
        drive(1, 4'b0000, 1);
        cycle();
        check("post-reset commit pos_x", int'(pos_x), 0);
        check("post-reset commit pos_y", int'(pos_y), 54);

        // Obstacle boundary: reset all instances, then one right tick.
        drive(0, 4'b0000, 0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        drive(1, 4'b0100, 0);
        blks_b = 0;
        blks_c = 0;
        repeat (4) cycle();
        drive(1, 4'b0100, 1);
        cycle();
        check("obstacle b blocked", blks_b, 1);
        check("obstacle b pos_x", int'(b_pos_x), 56);
        check("obstacle b pos_y", int'(b_pos_y), 10);
        check("obstacle c blocked", blks_c, 0);
        check("obstacle c pos_x", int'(c_pos_x), 57);
        check("obstacle c pos_y", int'(c_pos_y), 30);
        check("obstacle main pos_x", int'(pos_x), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
